event_trigger_scheduler: RTL
============================

# event_trigger_scheduler

Collects single-cycle event pulses from up to N_SRC counter event sources, such as the counter-equals-00, -80 and -FF flags. It holds each pulse as pending and serialises them onto one trigger-out endpoint bus. Grants are round-robin with a programmable hold-off between emitted triggers, so one trigger endpoint can be shared by all counters. Per-source saturating overflow counters record events that arrive while that source is already pending; they are intended for a wire-out.

## Interface

Parameters:
- N_SRC, 4, number of event sources (2..32)
- HOLD, 4, idle cycles forced after each emitted trigger (1..255)
- OVF_W, 8, width of each per-source overflow counter

Ports:
- sys_clk  in  1  sole clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- src_event  in  N_SRC  one-cycle event pulses, one bit per source
- src_enable  in  N_SRC  per-source enable, static from a wire-in
- clear  in  1  one-cycle pulse; clears pending bits and overflow counters
- trig_out  out  32  one-hot, one-cycle trigger word for the trigger-out endpoint; bits 31..N_SRC are always 0
- pending  out  N_SRC  current pending bits
- busy  out  1  high while state is not IDLE
- last_grant  out  5  index of the most recently granted source
- ovf_count  out  N_SRC*OVF_W  overflow count; source i occupies bits [i*OVF_W +: OVF_W]

## Operation

- Reset (async assert, sync release) sets:
  - state IDLE
  - trig_out, pending, busy and all ovf_count fields to 0
  - last_grant = N_SRC-1, so source 0 has first priority
- Capture:
  - An enabled source i with src_event[i]=1 at an edge sets pending[i] after that edge.
  - Events on disabled sources are ignored.
  - If src_enable[i]=0, pending[i] clears at the next edge.
- Overflow: src_event[i]=1 while pending[i] is already 1 and i is not being granted that cycle increments ovf_count[i]. The count saturates at 2^OVF_W-1 and never wraps.
- Grant selection: the first pending index searching upward from last_grant+1, modulo N_SRC.
- State machine:
  - IDLE: if any pending bit is set -> ISSUE with the selected source g.
  - ISSUE (1 cycle):
    - trig_out[g]=1; pending[g] clears; last_grant=g.
    - An event on g in this same cycle re-sets pending[g] without counting an overflow.
    - Always -> HOLDOFF with the hold counter loaded to HOLD.
  - HOLDOFF: the counter decrements each cycle. At count 1: -> ISSUE if any bit is pending (next grant selected that cycle), else -> IDLE.
- clear:
  - Zeroes pending and all ovf_count at the next edge.
  - clear wins over a same-cycle event on any source.
  - It does not abort ISSUE or HOLDOFF; the state sequence continues and finds nothing pending.
  - last_grant is unchanged.
- Arithmetic: the hold counter is 8 bits. Index search is combinational over N_SRC bits; no priority encoder may favour low indices except through last_grant.

## Timing

- trig_out is registered. An event sampled at edge k sets pending after k. From IDLE, trig_out is high for exactly the cycle after edge k+1, giving 2-edge latency.
- The minimum spacing between trigger pulses is HOLD+1 cycles, rising edge to rising edge. With HOLD=4, back-to-back grants are 5 cycles apart.
- trig_out is never high for two consecutive cycles and never has more than one bit set.
- busy is registered and equals (state != IDLE).
- reset_n asserted mid-ISSUE forces trig_out to 0 immediately (asynchronously).
- All inputs are synchronous to sys_clk. The trigger-in endpoint provides this for its outputs; wire-in outputs are static.

## Test plan

- Reset, then a single src_event[2] pulse at edge 10 -> trig_out = 32'h4 for one cycle after edge 11, last_grant=2, busy high for 1+4 cycles, then pending=0.
- Events on sources 0, 1 and 3 in the same cycle, HOLD=4 -> trig_out 0x1, 0x2, 0x8 in that order, each pulse 5 cycles after the previous one.
- Source 0 re-pulsed continuously while source 1 stays pending -> grants alternate 0, 1, 0, 1 (no starvation); ovf_count[0] increments once for each event on 0 that arrives while 0 is pending and not being granted, and does not increment on events coinciding with 0's grant cycle.
- 300 events on source 1 while it stays pending (trigger path kept busy by other sources) -> ovf_count[1] saturates at 255 and does not wrap; a clear pulse then sets it to 0 and pending to 0.
- src_enable[3]=0 with src_event[3] pulsed -> no trigger, pending[3]=0, ovf_count[3]=0; disabling source 3 while pending[3]=1 clears it at the next edge with no trigger emitted.
- reset_n pulled low during ISSUE -> trig_out drops to 0 immediately; after release, state is IDLE, last_grant=N_SRC-1, and all counters are 0.

Source files
------------

// File: rtl/event_trigger_scheduler_if.sv
// event_trigger_scheduler_if
// Bundles the event inputs and the trigger and status outputs of
// event_trigger_scheduler. The clock and reset are not part of the bundle.
//   master : drives src_event, src_enable and clear; observes the outputs
//   slave  : the scheduler side
// Signals:
//   src_event  [N_SRC]        one-cycle event pulses, one bit per source
//   src_enable [N_SRC]        per-source enable (static)
//   clear                     one-cycle pulse that clears pending and overflow counts
//   trig_out   [32]           one-hot, one-cycle trigger word
//   pending    [N_SRC]        current pending bits
//   busy                      scheduler not idle
//   last_grant [5]            index of the most recently granted source
//   ovf_count  [N_SRC*OVF_W]  per-source saturating overflow counters
interface event_trigger_scheduler_if #(
  parameter int N_SRC = 4,
  parameter int OVF_W = 8
) ();
  logic [N_SRC-1:0]       src_event;
  logic [N_SRC-1:0]       src_enable;
  logic                   clear;
  logic [31:0]            trig_out;
  logic [N_SRC-1:0]       pending;
  logic                   busy;
  logic [4:0]             last_grant;
  logic [N_SRC*OVF_W-1:0] ovf_count;

  modport master (
    output src_event, src_enable, clear,
    input  trig_out, pending, busy, last_grant, ovf_count
  );

  modport slave (
    input  src_event, src_enable, clear,
    output trig_out, pending, busy, last_grant, ovf_count
  );
endinterface

// File: rtl/event_trigger_scheduler.sv
// event_trigger_scheduler
// Latches single-cycle event pulses from N_SRC sources as pending bits and
// serialises them onto one trigger word. Grants are round-robin, starting
// after the last granted index. Every emitted trigger is followed by HOLD
// idle cycles. Per-source saturating counters record events that arrive
// while that source is already pending.
// Ports:
//   sys_clk  sole clock, rising edge
//   reset_n  asynchronous active-low reset, released synchronously upstream
//   bus      event_trigger_scheduler_if.slave (events, enables, clear, status)
module event_trigger_scheduler #(
  parameter int N_SRC = 4,
  parameter int HOLD  = 4,
  parameter int OVF_W = 8
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  event_trigger_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLDOFF} state_t;

  localparam logic [4:0] LAST_IDX = 5'(N_SRC - 1);

  state_t               state_reg, state_next;
  logic [7:0]           hold_reg, hold_next;
  logic [31:0]          trig_reg, trig_next;
  logic                 busy_reg, busy_next;
  logic [4:0]           last_grant_reg, last_grant_next;
  logic [N_SRC-1:0]     pending_reg;
  logic [N_SRC-1:0]     req;
  logic                 any_req;
  logic                 grant_fire;
  logic [4:0]           grant_idx;
  logic [4:0]           base;
  logic [4:0]           rot_off;
  logic [5:0]           grant_sum;
  logic [2*N_SRC-1:0]   req_dbl;
  logic [N_SRC-1:0]     req_rot;

  // A source whose enable has dropped is never granted, even on the edge
  // where its pending bit is being cleared.
  assign req     = pending_reg & bus.src_enable;
  assign any_req = |req;

  // Round-robin search: rotate the request vector so the slot after
  // last_grant sits at bit 0, take the lowest set bit of the rotated vector,
  // then map the offset back to a source index modulo N_SRC.
  assign base    = (last_grant_reg >= LAST_IDX) ? 5'd0 : last_grant_reg + 5'd1;
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[base +: N_SRC];

  always_comb begin
    rot_off = 5'd0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (req_rot[k]) rot_off = 5'(k);
    end
    grant_sum = {1'b0, base} + {1'b0, rot_off};
    if (grant_sum >= 6'(N_SRC)) grant_idx = 5'(grant_sum - 6'(N_SRC));
    else                        grant_idx = grant_sum[4:0];
  end

  // State register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      hold_reg  <= 8'd0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // Next-state logic. grant_fire marks the edge that enters ISSUE; the
  // trigger word, last_grant and the granted pending bit all update on it.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    grant_fire = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
          grant_fire = 1'b1;
        end
      end
      ISSUE: begin
        state_next = HOLDOFF;
        hold_next  = 8'(HOLD);
      end
      HOLDOFF: begin
        if (hold_reg == 8'd1) begin
          if (any_req) begin
            state_next = ISSUE;
            grant_fire = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          hold_next = hold_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic, registered below so trig_out is high exactly while in ISSUE.
  always_comb begin
    trig_next       = grant_fire ? (32'd1 << grant_idx) : 32'd0;
    busy_next       = (state_next != IDLE);
    last_grant_next = grant_fire ? grant_idx : last_grant_reg;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_reg       <= 32'd0;
      busy_reg       <= 1'b0;
      last_grant_reg <= LAST_IDX;
    end else begin
      trig_reg       <= trig_next;
      busy_reg       <= busy_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Per-source pending bit and overflow counter.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    logic             granted;
    logic             pending_bit_reg, pending_bit_next;
    logic [OVF_W-1:0] ovf_reg, ovf_next;

    assign granted = grant_fire && (grant_idx == 5'(gi));

    // clear beats everything; a new event beats the grant so an event on
    // the granted edge keeps the source pending without counting overflow.
    always_comb begin
      pending_bit_next = pending_bit_reg;
      ovf_next         = ovf_reg;
      if (bus.clear) begin
        pending_bit_next = 1'b0;
        ovf_next         = '0;
      end else if (!bus.src_enable[gi]) begin
        pending_bit_next = 1'b0;
      end else if (bus.src_event[gi]) begin
        pending_bit_next = 1'b1;
        if (pending_bit_reg && !granted && (ovf_reg != '1))
          ovf_next = ovf_reg + OVF_W'(1);
      end else if (granted) begin
        pending_bit_next = 1'b0;
      end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
        pending_bit_reg <= 1'b0;
        ovf_reg         <= '0;
      end else begin
        pending_bit_reg <= pending_bit_next;
        ovf_reg         <= ovf_next;
      end
    end

    assign pending_reg[gi]                  = pending_bit_reg;
    assign bus.ovf_count[gi*OVF_W +: OVF_W] = ovf_reg;
  end

  assign bus.trig_out   = trig_reg;
  assign bus.pending    = pending_reg;
  assign bus.busy       = busy_reg;
  assign bus.last_grant = last_grant_reg;

endmodule
